// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency LSU port between the core (m0)
// and a debug/loader master (m1), routing each load's data back to its issuer.
module lsu_arbiter #(
  parameter int RD_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_wdata,
  input  logic [2:0]  i_m0_type_access,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m1_type_access,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,

  output logic [31:0] o_mem_addr,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_type_access,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("lsu_arbiter: RD_LATENCY must be in 1..4");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_t     state;
  logic [1:0] cnt;       // cycles left until the outstanding load's data arrives
  logic       owner;     // 1 = outstanding load belongs to m1
  logic       last_m1;   // 1 = m1 received the most recent grant

  logic can_grant;
  logic rd_done;
  logic issue_load;

  // Everything is held quiet while reset is high, even though the registered
  // state only clears on the following edge.
  assign rd_done    = !i_reset && (state == RD_WAIT) && (cnt == 2'd0);
  assign can_grant  = !i_reset && ((state == IDLE) || (cnt == 2'd0));

  assign o_m0_gnt   = can_grant && i_m0_req && (!i_m1_req ||  last_m1);
  assign o_m1_gnt   = can_grant && i_m1_req && (!i_m0_req || !last_m1);
  assign issue_load = (o_m0_gnt && !i_m0_wren) || (o_m1_gnt && !i_m1_wren);

  assign o_m0_rvalid = rd_done && !owner;
  assign o_m1_rvalid = rd_done &&  owner;
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : 32'd0;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : 32'd0;
  assign o_busy      = !i_reset && (state == RD_WAIT) && (cnt != 2'd0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    o_mem_addr        = 32'd0;
    o_mem_wren        = 1'b0;
    o_mem_wdata       = 32'd0;
    o_mem_type_access = 3'd0;
    if (o_m0_gnt) begin
      o_mem_addr        = i_m0_addr;
      o_mem_wren        = i_m0_wren;
      o_mem_wdata       = i_m0_wdata;
      o_mem_type_access = i_m0_type_access;
    end else if (o_m1_gnt) begin
      o_mem_addr        = i_m1_addr;
      o_mem_wren        = i_m1_wren;
      o_mem_wdata       = i_m1_wdata;
      o_mem_type_access = i_m1_type_access;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      owner   <= 1'b0;
      last_m1 <= 1'b1;
    end else begin
      if (o_m0_gnt || o_m1_gnt) begin
        last_m1 <= o_m1_gnt;
      end
      // A new load may be issued in the same cycle the previous one returns.
      if (issue_load) begin
        state <= RD_WAIT;
        cnt   <= LAT_M1;
        owner <= o_m1_gnt;
      end else if (state == RD_WAIT) begin
        if (cnt == 2'd0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed vector table, randomized run against a
// timestamp-based reference model, and hand-written multi-cycle sequences.
module tb_lsu_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wren, m1_req, m1_wren;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [2:0]  m0_type, m1_type;

  // index 0: RD_LATENCY=2 instance, index 1: RD_LATENCY=1 instance
  logic [1:0]        m0_gnt, m1_gnt, m0_rv, m1_rv, busy, mem_wren;
  logic [1:0][31:0]  m0_rd, m1_rd, mem_addr, mem_wdata;
  logic [1:0][2:0]   mem_type;

  int tests = 0;
  int fails = 0;

  lsu_arbiter #(.RD_LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wren(m0_wren),
    .i_m0_wdata(m0_wdata), .i_m0_type_access(m0_type),
    .o_m0_gnt(m0_gnt[0]), .o_m0_rvalid(m0_rv[0]), .o_m0_rdata(m0_rd[0]),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wren(m1_wren),
    .i_m1_wdata(m1_wdata), .i_m1_type_access(m1_type),
    .o_m1_gnt(m1_gnt[0]), .o_m1_rvalid(m1_rv[0]), .o_m1_rdata(m1_rd[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wren(mem_wren[0]), .o_mem_wdata(mem_wdata[0]),
    .o_mem_type_access(mem_type[0]), .i_mem_rdata(mem_rdata), .o_busy(busy[0])
  );

  lsu_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wren(m0_wren),
    .i_m0_wdata(m0_wdata), .i_m0_type_access(m0_type),
    .o_m0_gnt(m0_gnt[1]), .o_m0_rvalid(m0_rv[1]), .o_m0_rdata(m0_rd[1]),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wren(m1_wren),
    .i_m1_wdata(m1_wdata), .i_m1_type_access(m1_type),
    .o_m1_gnt(m1_gnt[1]), .o_m1_rvalid(m1_rv[1]), .o_m1_rdata(m1_rd[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wren(mem_wren[1]), .o_mem_wdata(mem_wdata[1]),
    .o_mem_type_access(mem_type[1]), .i_mem_rdata(mem_rdata), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Directed vector: inputs of one cycle plus the expected outputs of the
  // RD_LATENCY=2 instance in that cycle.
  typedef struct {
    bit          rst;
    bit          r0, w0, r1, w1;
    logic [31:0] a0, a1, rd_in;
    bit          g0, g1, v0, v1, busy;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rs, bit r0, bit w0, logic [31:0] a0,
                             bit r1, bit w1, logic [31:0] a1, logic [31:0] rd_in,
                             bit g0, bit g1, bit v0, bit v1, bit bz, logic [31:0] rdata);
    vec_t t;
    t.rst = rs; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.r1 = r1; t.w1 = w1; t.a1 = a1;
    t.rd_in = rd_in; t.g0 = g0; t.g1 = g1; t.v0 = v0; t.v1 = v1; t.busy = bz;
    t.rdata = rdata;
    return t;
  endfunction

  // Reference model: tracks the cycle at which the port frees up and the
  // cycle at which the pending load's data is due, rather than any FSM.
  int next_ok[2];
  int due[2];
  bit pend[2];
  bit own[2];
  bit last_m1[2];

  task automatic model_check(input int k, input int now);
    int          lat, win;
    bit          eg0, eg1, ev0, ev1, eb, ew;
    logic [31:0] ea, ewd, erd0, erd1;
    logic [2:0]  et;
    lat = (k == 0) ? 2 : 1;
    win = -1;
    {eg0, eg1, ev0, ev1, eb, ew} = '0;
    ea = '0; ewd = '0; et = '0;
    if (rst) begin
      pend[k] = 1'b0; last_m1[k] = 1'b1; next_ok[k] = now + 1;
    end else begin
      ev0 = pend[k] && due[k] == now && !own[k];
      ev1 = pend[k] && due[k] == now &&  own[k];
      eb  = pend[k] && now < due[k];
      if (now >= next_ok[k]) begin
        if (m0_req && m1_req) win = last_m1[k] ? 0 : 1;
        else if (m0_req)      win = 0;
        else if (m1_req)      win = 1;
      end
      if (pend[k] && due[k] == now) pend[k] = 1'b0;
      if (win >= 0) begin
        last_m1[k] = (win == 1);
        eg0 = (win == 0); eg1 = (win == 1);
        ew  = eg0 ? m0_wren  : m1_wren;
        ea  = eg0 ? m0_addr  : m1_addr;
        ewd = eg0 ? m0_wdata : m1_wdata;
        et  = eg0 ? m0_type  : m1_type;
        if (ew) next_ok[k] = now + 1;
        else begin
          pend[k] = 1'b1; due[k] = now + lat; own[k] = (win == 1); next_ok[k] = now + lat;
        end
      end
    end
    erd0 = ev0 ? mem_rdata : 32'd0;
    erd1 = ev1 ? mem_rdata : 32'd0;
    check($sformatf("rnd%0d.%0d ctl", now, k),
          {58'd0, m0_gnt[k], m1_gnt[k], m0_rv[k], m1_rv[k], busy[k], mem_wren[k]},
          {58'd0, eg0, eg1, ev0, ev1, eb, ew});
    check($sformatf("rnd%0d.%0d addr", now, k), {32'd0, mem_addr[k]}, {32'd0, ea});
    check($sformatf("rnd%0d.%0d wdata", now, k), {29'd0, mem_type[k], mem_wdata[k]}, {29'd0, et, ewd});
    check($sformatf("rnd%0d.%0d rdata", now, k), {m0_rd[k], m1_rd[k]}, {erd0, erd1});
  endtask

  task automatic drive(input bit rs, input bit r0, input bit w0, input logic [31:0] a0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] rd_in);
    rst = rs; m0_req = r0; m0_wren = w0; m0_addr = a0; m1_req = r1; m1_wren = w1; m1_addr = a1;
    m0_wdata = 32'h11; m1_wdata = 32'h22; m0_type = 3'b010; m1_type = 3'b101;
    mem_rdata = rd_in;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    int   g1c, m0c, v1c;

    // reset with requests present, then single load (0xDEADBEEF after 2 cycles)
    vecs.push_back(v(1, 1,0,32'h100, 1,0,32'h200, 0,            0,0,0,0,0, 0));
    vecs.push_back(v(0, 1,0,32'h100, 0,0,0,       0,            1,0,0,0,0, 0));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       0,            0,0,0,0,1, 0));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'hDEADBEEF, 0,0,1,0,0, 32'hDEADBEEF));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'h1234,     0,0,0,0,0, 0));
    // both masters loading continuously from reset
    vecs.push_back(v(1, 0,0,0,       0,0,0,       0,            0,0,0,0,0, 0));
    vecs.push_back(v(0, 1,0,32'h200, 1,0,32'h300, 0,            1,0,0,0,0, 0));
    vecs.push_back(v(0, 1,0,32'h204, 1,0,32'h300, 32'h5555,     0,0,0,0,1, 0));
    vecs.push_back(v(0, 1,0,32'h204, 1,0,32'h300, 32'hA1,       0,1,1,0,0, 32'hA1));
    vecs.push_back(v(0, 1,0,32'h204, 1,0,32'h304, 0,            0,0,0,0,1, 0));
    vecs.push_back(v(0, 1,0,32'h204, 1,0,32'h304, 32'hA2,       1,0,0,1,0, 32'hA2));
    vecs.push_back(v(0, 1,0,32'h208, 1,0,32'h304, 0,            0,0,0,0,1, 0));
    vecs.push_back(v(0, 1,0,32'h208, 1,0,32'h304, 32'hA3,       0,1,1,0,0, 32'hA3));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       0,            0,0,0,0,1, 0));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'hA4,       0,0,0,1,0, 32'hA4));
    // both masters storing every cycle: one grant per cycle, alternating
    vecs.push_back(v(0, 1,1,32'h10,  1,1,32'h20,  32'h77,       1,0,0,0,0, 0));
    vecs.push_back(v(0, 1,1,32'h10,  1,1,32'h20,  32'h77,       0,1,0,0,0, 0));
    vecs.push_back(v(0, 1,1,32'h10,  1,1,32'h20,  32'h77,       1,0,0,0,0, 0));
    vecs.push_back(v(0, 1,1,32'h10,  1,1,32'h20,  32'h77,       0,1,0,0,0, 0));
    // reset in cycle 1 of a load: old load dropped, grant right after reset
    vecs.push_back(v(0, 1,0,32'h100, 0,0,0,       0,            1,0,0,0,0, 0));
    vecs.push_back(v(1, 1,0,32'h100, 1,0,32'h200, 0,            0,0,0,0,0, 0));
    vecs.push_back(v(0, 1,0,32'h140, 0,0,0,       32'hBAD,      1,0,0,0,0, 0));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'hBAD,      0,0,0,0,1, 0));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'h55,       0,0,1,0,0, 32'h55));
    vecs.push_back(v(0, 0,0,0,       0,0,0,       32'h66,       0,0,0,0,0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t.rst, t.r0, t.w0, t.a0, t.r1, t.w1, t.a1, t.rd_in);
      @(negedge clk);
      check($sformatf("vec%0d ctl", i),
            {58'd0, m0_gnt[0], m1_gnt[0], m0_rv[0], m1_rv[0], busy[0], mem_wren[0]},
            {58'd0, t.g0, t.g1, t.v0, t.v1, t.busy,
             t.g0 ? t.w0 : (t.g1 ? t.w1 : 1'b0)});
      check($sformatf("vec%0d addr", i), {32'd0, mem_addr[0]},
            {32'd0, t.g0 ? t.a0 : (t.g1 ? t.a1 : 32'd0)});
      check($sformatf("vec%0d wdata", i), {29'd0, mem_type[0], mem_wdata[0]},
            t.g0 ? {29'd0, 3'b010, 32'h11} : (t.g1 ? {29'd0, 3'b101, 32'h22} : 64'd0));
      check($sformatf("vec%0d rdata", i), {m0_rd[0], m1_rd[0]},
            {t.v0 ? t.rdata : 32'd0, t.v1 ? t.rdata : 32'd0});
      next_cycle();
    end

    // randomized traffic on both instances against the reference model
    for (int n = 0; n < 600; n++) begin
      rst       = (n == 0) || ($urandom_range(0, 59) == 0);
      m0_req    = 1'($urandom_range(0, 1));
      m1_req    = 1'($urandom_range(0, 1));
      m0_wren   = ($urandom_range(0, 2) == 0);
      m1_wren   = ($urandom_range(0, 2) == 0);
      m0_addr   = $urandom;  m1_addr  = $urandom;
      m0_wdata  = $urandom;  m1_wdata = $urandom;
      m0_type   = 3'($urandom); m1_type = 3'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_check(k, n);
      next_cycle();
    end

    // RD_LATENCY=1: four back-to-back m0 loads
    drive(1, 0,0,0, 0,0,0, 0);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      drive(0, c < 4, 0, 32'h400 + 32'(4 * c), 0,0,0, (c >= 1) ? 32'hC0DE0000 + 32'(c - 1) : 32'hFFFF);
      @(negedge clk);
      check($sformatf("t5 c%0d gnt/rv", c), {62'd0, m0_gnt[1], m0_rv[1]}, {62'd0, c < 4, c >= 1});
      check($sformatf("t5 c%0d rdata", c), {32'd0, m0_rd[1]},
            {32'd0, (c >= 1) ? 32'hC0DE0000 + 32'(c - 1) : 32'd0});
      next_cycle();
    end

    // m0 streams stores, m1 raises a load in cycle 3 and holds it until granted
    drive(1, 0,0,0, 0,0,0, 0);
    next_cycle();
    g1c = -1; m0c = -1; v1c = -1;
    for (int c = 0; c < 12; c++) begin
      drive(0, 1,1,32'h10, (c >= 3) && (g1c < 0), 0, 32'h20, 32'h900 + 32'(c));
      @(negedge clk);
      if (m1_gnt[0] && g1c < 0) g1c = c;
      if (m0_gnt[0] && g1c >= 0 && c > g1c && m0c < 0) m0c = c;
      if (m1_rv[0] && v1c < 0) v1c = c;
      next_cycle();
    end
    check("t6 m1 granted in cycle 3 or 4", {63'd0, (g1c == 3) || (g1c == 4)}, 64'd1);
    check("t6 m0 resumes at rvalid cycle", 64'(m0c), 64'(g1c + 2));
    check("t6 m1 rvalid cycle", 64'(v1c), 64'(g1c + 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
